// File: rtl/eq_queue_pkg.sv
// eq_queue_pkg
// Shared types and pointer helpers for the equalizer window queue.
//   state_t  : replay state machine encoding (IDLE, PRIME, READ)
//   ptr_inc  : wrap-around increment of a pointer into a DEPTH-entry store
//   ptr_sub  : modulo-DEPTH subtraction (n must not exceed depth)
// The helpers work on 32-bit values so that DEPTH does not need to be a
// power of two; callers truncate the result back to their pointer width.
package eq_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        READ  = 2'd2
    } state_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic int unsigned ptr_sub(input int unsigned ptr, input int unsigned n,
                                            input int unsigned depth);
        return (ptr >= n) ? ptr - n : ptr + depth - n;
    endfunction

endpackage

// File: rtl/eq_window_queue_if.sv
// eq_window_queue_if
// Sample/replay bus between a sample producer and the window queue.
//   wrt_smpl   : one-cycle write strobe for smpl_in
//   smpl_in    : packed input samples (W bits)
//   smpl_out   : packed replayed samples (W bits)
//   smpl_vld   : smpl_out valid this cycle
//   sequencing : replay in progress (PRIME + READ)
//   full       : a whole window has been stored since reset
//   ovrn       : sticky overrun flag
// Modports: master = producer/consumer side, slave = the queue.
interface eq_window_queue_if #(
    parameter int W = 32
);
    logic         wrt_smpl;
    logic [W-1:0] smpl_in;
    logic [W-1:0] smpl_out;
    logic         smpl_vld;
    logic         sequencing;
    logic         full;
    logic         ovrn;

    modport master (
        output wrt_smpl, smpl_in,
        input  smpl_out, smpl_vld, sequencing, full, ovrn
    );

    modport slave (
        input  wrt_smpl, smpl_in,
        output smpl_out, smpl_vld, sequencing, full, ovrn
    );
endinterface

// File: rtl/eq_dp_ram.sv
// eq_dp_ram
// Simple dual-port RAM: synchronous write, one-cycle synchronous read.
// A read of the address being written in the same cycle returns the old
// contents. Contents are not reset.
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data (WIDTH bits)
//   rd_addr : read address, data appears on rd_data one cycle later
//   rd_data : registered read data
module eq_dp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1536
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write and read share one clocked process; the read sees the array
    // value from before this edge, which gives read-old-on-collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/eq_window_queue.sv
// eq_window_queue
// Circular sample store for the equalizer FIR path. Once WIN samples are
// stored, every DECIM-th write (starting with the write that completes the
// first window) replays the latest WIN samples, oldest to newest, one per
// clock.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : eq_window_queue_if.slave (write strobe/data in, replay out,
//           full and ovrn status)
// Optional feature: define EQ_WIN_OVRN_EN to enable the sticky overrun
// flag (trigger during replay, or too many writes during one replay).
// Without it ovrn is tied low.
module eq_window_queue
    import eq_queue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 1536,
    parameter int WIN    = 1021,
    parameter int DECIM  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    eq_window_queue_if.slave bus
);
    localparam int W      = NUM_CH * DATA_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(WIN + 1);
    localparam int CNT_W  = $clog2(WIN);
    localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [DEC_W-1:0]   decim_cnt_q, decim_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               full_q, full_d;
    logic               smpl_vld_q, smpl_vld_d;
    logic               sequencing_q, sequencing_d;
    logic               win_ready;
    logic               trigger;
    logic [W-1:0]       ram_rd_data;

    eq_dp_ram #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bus.wrt_smpl),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.smpl_in),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Next-state logic. A write is "window ready" once it completes or
    // follows a full window; the decimation counter only runs on such
    // writes and a trigger fires when it is at zero, so the write that
    // completes the first window always fires.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        decim_cnt_d  = decim_cnt_q;
        rd_cnt_d     = rd_cnt_q;

        win_ready = (fill_q == FILL_W'(WIN)) || (fill_q == FILL_W'(WIN - 1));
        trigger   = bus.wrt_smpl && win_ready && (decim_cnt_q == '0);

        if (bus.wrt_smpl) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
            if (fill_q != FILL_W'(WIN)) begin
                fill_d = fill_q + 1'b1;
            end
            if (win_ready) begin
                decim_cnt_d = (decim_cnt_q == DEC_W'(DECIM - 1)) ? '0 : decim_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                // The oldest window sample is WIN behind the post-write
                // pointer, so the trigger sample itself is read last.
                if (trigger) begin
                    rd_ptr_d = PTR_W'(ptr_sub(32'(wr_ptr_d), WIN, DEPTH));
                    rd_cnt_d = '0;
                    state_d  = PRIME;
                end
            end
            PRIME: begin
                rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
                state_d  = READ;
            end
            READ: begin
                rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == CNT_W'(WIN - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        full_d       = (fill_d == FILL_W'(WIN));
        sequencing_d = (state_d != IDLE);
        smpl_vld_d   = (state_d == READ);
    end

    // State and status registers; status outputs are registered from the
    // next state so they line up with the RAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            decim_cnt_q  <= '0;
            rd_cnt_q     <= '0;
            full_q       <= 1'b0;
            smpl_vld_q   <= 1'b0;
            sequencing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            decim_cnt_q  <= decim_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            full_q       <= full_d;
            smpl_vld_q   <= smpl_vld_d;
            sequencing_q <= sequencing_d;
        end
    end

    assign bus.smpl_out   = ram_rd_data;
    assign bus.smpl_vld   = smpl_vld_q;
    assign bus.sequencing = sequencing_q;
    assign bus.full       = full_q;

`ifdef EQ_WIN_OVRN_EN
    localparam int RW_W = $clog2(DEPTH);

    logic [RW_W-1:0] rp_wr_cnt_q, rp_wr_cnt_d;
    logic            ovrn_q, ovrn_d;

    // Overrun detection: a trigger arriving mid-replay, or the write that
    // would exceed DEPTH-WIN-1 writes during one replay (it could then
    // overwrite samples not yet read out).
    always_comb begin
        rp_wr_cnt_d = rp_wr_cnt_q;
        ovrn_d      = ovrn_q;
        if (state_q == IDLE) begin
            rp_wr_cnt_d = '0;
        end else if (bus.wrt_smpl) begin
            if (trigger) begin
                ovrn_d = 1'b1;
            end
            if (rp_wr_cnt_q == RW_W'(DEPTH - WIN - 1)) begin
                ovrn_d = 1'b1;
            end else begin
                rp_wr_cnt_d = rp_wr_cnt_q + 1'b1;
            end
        end
    end

    // Sticky overrun flag and its per-replay write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_wr_cnt_q <= '0;
            ovrn_q      <= 1'b0;
        end else begin
            rp_wr_cnt_q <= rp_wr_cnt_d;
            ovrn_q      <= ovrn_d;
        end
    end

    assign bus.ovrn = ovrn_q;
`else
    assign bus.ovrn = 1'b0;
`endif

endmodule

// File: tb/tb_eq_window_queue.sv
// tb_eq_window_queue
// Self-checking bench for eq_window_queue. Three instances:
//   dut_a : DEPTH=16, WIN=8, DECIM=1
//   dut_b : DEPTH=16, WIN=8, DECIM=4
//   dut_c : default parameters (1536/1021/1)
// Each write that should trigger pushes the expected window onto a
// per-instance scoreboard queue; monitors pop and compare on smpl_vld.
module tb_eq_window_queue;
    localparam int W     = 32;
    localparam int WIN_S = 8;
    localparam int WIN_L = 1021;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] hist_a[$], hist_b[$], hist_c[$];
    logic [W-1:0] exp_a[$],  exp_b[$],  exp_c[$];

    always #5 clk = ~clk;

    eq_window_queue_if #(.W(W)) bus_a ();
    eq_window_queue_if #(.W(W)) bus_b ();
    eq_window_queue_if #(.W(W)) bus_c ();

    eq_window_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(16), .WIN(WIN_S), .DECIM(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    eq_window_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(16), .WIN(WIN_S), .DECIM(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    eq_window_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(1536), .WIN(WIN_L), .DECIM(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ch0 = n, ch1 = n + 100
    function automatic logic [W-1:0] pack(input int n);
        return {16'(n + 100), 16'(n)};
    endfunction

    // Status bits of one instance as {ovrn, full, sequencing, smpl_vld}.
    function automatic logic [3:0] getFlags(input int sel);
        case (sel)
            0:       return {bus_a.ovrn, bus_a.full, bus_a.sequencing, bus_a.smpl_vld};
            1:       return {bus_b.ovrn, bus_b.full, bus_b.sequencing, bus_b.smpl_vld};
            default: return {bus_c.ovrn, bus_c.full, bus_c.sequencing, bus_c.smpl_vld};
        endcase
    endfunction

    // Expected window: the last WIN samples written, oldest first.
    function automatic void pushWindow(input int sel);
        case (sel)
            0: for (int i = hist_a.size() - WIN_S; i < hist_a.size(); i++) exp_a.push_back(hist_a[i]);
            1: for (int i = hist_b.size() - WIN_S; i < hist_b.size(); i++) exp_b.push_back(hist_b[i]);
            default: for (int i = hist_c.size() - WIN_L; i < hist_c.size(); i++) exp_c.push_back(hist_c[i]);
        endcase
    endfunction

    // One-cycle write strobe; returns at the negedge after the write edge
    // and checks sequencing there.
    task automatic applyStimulus(input int sel, input logic [W-1:0] data, input bit trig,
                                 input bit exp_seq);
        @(negedge clk);
        case (sel)
            0: begin bus_a.wrt_smpl = 1'b1; bus_a.smpl_in = data; hist_a.push_back(data); end
            1: begin bus_b.wrt_smpl = 1'b1; bus_b.smpl_in = data; hist_b.push_back(data); end
            default: begin bus_c.wrt_smpl = 1'b1; bus_c.smpl_in = data; hist_c.push_back(data); end
        endcase
        if (trig) pushWindow(sel);
        @(negedge clk);
        bus_a.wrt_smpl = 1'b0;
        bus_b.wrt_smpl = 1'b0;
        bus_c.wrt_smpl = 1'b0;
        checkOutput($sformatf("seq_after_write_%0d", sel), W'(getFlags(sel)[1]), W'(exp_seq));
    endtask

    // Waits (bounded) for the replay to end, counting valid cycles.
    task automatic waitWindow(input int sel, input int nvld, input string tag);
        int n    = 0;
        int vlds = 0;
        while (getFlags(sel)[1] === 1'b1 && n < 3000) begin
            if (getFlags(sel)[0] === 1'b1) vlds++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ended"}, W'(getFlags(sel)[1]), W'(0));
        checkOutput({tag, "_vld_count"}, W'(vlds), W'(nvld));
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus_a.smpl_vld !== 1'b0) begin
            checkOutput("a_sb_nonempty", W'(exp_a.size() != 0), W'(1));
            if (exp_a.size() != 0) checkOutput("a_data", bus_a.smpl_out, exp_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus_b.smpl_vld !== 1'b0) begin
            checkOutput("b_sb_nonempty", W'(exp_b.size() != 0), W'(1));
            if (exp_b.size() != 0) checkOutput("b_data", bus_b.smpl_out, exp_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus_c.smpl_vld !== 1'b0) begin
            checkOutput("c_sb_nonempty", W'(exp_c.size() != 0), W'(1));
            if (exp_c.size() != 0) checkOutput("c_data", bus_c.smpl_out, exp_c.pop_front());
        end
    end

    initial begin
        bus_a.wrt_smpl = 1'b0; bus_a.smpl_in = '0;
        bus_b.wrt_smpl = 1'b0; bus_b.smpl_in = '0;
        bus_c.wrt_smpl = 1'b0; bus_c.smpl_in = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("reset_flags_%0d", s), W'(getFlags(s)), W'(0));
        end

        // First window on dut_a: 1..8 back to back.
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(0, pack(n), n == 8, n == 8);
            if (n == 7) checkOutput("a_full_w7", W'(bus_a.full), W'(0));
        end
        checkOutput("a_full_w8", W'(bus_a.full), W'(1));
        checkOutput("a_prime_vld", W'(bus_a.smpl_vld), W'(0));
        waitWindow(0, WIN_S, "a_first");

        // Every write triggers once full; window for 20 crosses the wrap.
        for (int n = 9; n <= 20; n++) begin
            applyStimulus(0, pack(n), 1'b1, 1'b1);
            waitWindow(0, WIN_S, $sformatf("a_win%0d", n));
            repeat (2) @(negedge clk);
        end
        checkOutput("a_drained", W'(exp_a.size()), W'(0));

        // Decimated triggering on dut_b: windows after 8, 12, 16 only.
        for (int n = 1; n <= 16; n++) begin
            bit trig;
            trig = (n == 8) || (n == 12) || (n == 16);
            applyStimulus(1, pack(n), trig, trig);
            if (trig) waitWindow(1, WIN_S, $sformatf("b_win%0d", n));
            else repeat (10) @(negedge clk);
        end
        checkOutput("b_drained", W'(exp_b.size()), W'(0));

        // Reset in the 4th READ cycle of dut_a aborts the replay.
        applyStimulus(0, pack(21), 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("a_read4_vld", W'(bus_a.smpl_vld), W'(1));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("a_rst_vld", W'(bus_a.smpl_vld), W'(0));
        checkOutput("a_rst_seq", W'(bus_a.sequencing), W'(0));
        checkOutput("a_rst_full", W'(bus_a.full), W'(0));
        exp_a.delete(); hist_a.delete(); hist_b.delete(); hist_c.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int n = 1; n <= 7; n++) applyStimulus(0, pack(n), 1'b0, 1'b0);
        checkOutput("a_post_rst_full7", W'(bus_a.full), W'(0));
        applyStimulus(0, pack(8), 1'b1, 1'b1);
        waitWindow(0, WIN_S, "a_post_rst");

        // Trigger on 10 arrives mid-replay of 2..9 and is dropped.
        applyStimulus(0, pack(9), 1'b1, 1'b1);
        applyStimulus(0, pack(10), 1'b0, 1'b1);
`ifdef EQ_WIN_OVRN_EN
        checkOutput("a_ovrn_drop", W'(bus_a.ovrn), W'(1));
`else
        checkOutput("a_ovrn_drop", W'(bus_a.ovrn), W'(0));
`endif
        waitWindow(0, WIN_S - 1, "a_drop");
        repeat (3) @(negedge clk);
        checkOutput("a_no_restart", W'(bus_a.sequencing), W'(0));
        checkOutput("a_drained2", W'(exp_a.size()), W'(0));

        // Default-parameter instance: 1021 random writes, one full window.
        for (int n = 1; n <= WIN_L; n++) begin
            applyStimulus(2, W'($urandom), n == WIN_L, n == WIN_L);
        end
        checkOutput("c_full", W'(bus_c.full), W'(1));
        waitWindow(2, WIN_L, "c_win");
        checkOutput("c_drained", W'(exp_c.size()), W'(0));
        checkOutput("c_ovrn", W'(bus_c.ovrn), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
